// File: rtl/pipeline_one_tx.sv
// Link-side transmitter: captures a frame of four routed flits and replays them as strobed payloads
// on a shared bus, closing with a clksig pulse. Optional feature macro: TX_SKIP_INVALID_EN.
`default_nettype none

module pipeline_one_tx #(
    parameter int PAYLOAD_W  = 7,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_in,
    input  logic [PAYLOAD_W+3:0]   noun,
    input  logic [PAYLOAD_W+3:0]   soun,
    input  logic [PAYLOAD_W+3:0]   eoun,
    input  logic [PAYLOAD_W+3:0]   woun,
    output logic [PAYLOAD_W-1:0]   inc,
    output logic                   nsig,
    output logic                   ssig,
    output logic                   esig,
    output logic                   wsig,
    output logic                   clksig,
    output logic                   busy,
    output logic                   ovf,
    output logic [1:0]             o_dbg_state,
    output logic [1:0]             o_dbg_slot,
    output logic [11:0]            o_dbg_meta
);

    localparam int FLIT_W = PAYLOAD_W + 4;
    localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GAP   = 2'd2,
        ST_CLOSE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_slot;
    logic [1:0]            w_slot_nxt;
    logic [3:0]            r_gap_cnt;
    logic [3:0]            w_gap_nxt;
    logic                  w_accept;

    logic [FLIT_W-1:0]     w_in   [4];
    logic [FLIT_W-1:0]     r_hold [4];

    logic                  w_start_found;
    logic [1:0]            w_start_slot;
    logic                  w_adv_found;
    logic [1:0]            w_adv_slot;

    logic                  w_sel_valid;
    logic [PAYLOAD_W-1:0]  w_sel_payload;
    logic [PAYLOAD_W-1:0]  w_inc_nxt;
    logic [3:0]            w_sig_nxt;

    logic [PAYLOAD_W-1:0]  r_inc;
    logic [3:0]            r_sig;
    logic                  r_clksig;
    logic                  r_busy;
    logic                  r_ovf;

    // Slot order on the link is fixed: 0=N, 1=S, 2=E, 3=W.
    assign w_in[0] = noun;
    assign w_in[1] = soun;
    assign w_in[2] = eoun;
    assign w_in[3] = woun;

`ifdef TX_SKIP_INVALID_EN
    logic [3:0] w_vmask_in;
    logic [3:0] w_vmask_hold;
    logic [2:0] w_start_srch;
    logic [2:0] w_adv_srch;

    // Lowest valid slot at or above 'from'; bit 2 of the result flags a hit.
    function automatic logic [2:0] next_valid(input logic [3:0] vmask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (vmask[i] && (3'(i) >= from)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_vmask_in   = '0;
        w_vmask_hold = '0;
        for (int i = 0; i < 4; i++) begin
            w_vmask_in[i]   = w_in[i][FLIT_W-1];
            w_vmask_hold[i] = r_hold[i][FLIT_W-1];
        end
    end

    assign w_start_srch  = next_valid(w_vmask_in, 3'd0);
    assign w_adv_srch    = next_valid(w_vmask_hold, {1'b0, r_slot} + 3'd1);
    assign w_start_found = w_start_srch[2];
    assign w_start_slot  = w_start_srch[1:0];
    assign w_adv_found   = w_adv_srch[2];
    assign w_adv_slot    = w_adv_srch[1:0];
`else
    assign w_start_found = 1'b1;
    assign w_start_slot  = 2'd0;
    assign w_adv_found   = (r_slot != 2'd3);
    assign w_adv_slot    = r_slot + 2'd1;
`endif

    // frame_in is a one-shot request: accepted only in IDLE, any other cycle (CLOSE included)
    // leaves the hold registers alone and raises the sticky overflow flag.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_gap_nxt   = r_gap_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (frame_in) begin
                    w_accept = 1'b1;
                    if (w_start_found) begin
                        w_state_nxt = ST_SEND;
                        w_slot_nxt  = w_start_slot;
                    end else begin
                        w_state_nxt = ST_CLOSE;
                        w_slot_nxt  = 2'd0;
                    end
                end
            end
            ST_SEND: begin
                if (GAP_CYCLES > 0) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_INIT;
                end else if (w_adv_found) begin
                    w_state_nxt = ST_SEND;
                    w_slot_nxt  = w_adv_slot;
                end else begin
                    w_state_nxt = ST_CLOSE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt != 4'd0) begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end else if (w_adv_found) begin
                    w_state_nxt = ST_SEND;
                    w_slot_nxt  = w_adv_slot;
                end else begin
                    w_state_nxt = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear in the same cycle the state does;
    // on acceptance the hold registers are not loaded yet, so read the inputs directly.
    always_comb begin
        w_sel_valid   = w_accept ? w_in[w_slot_nxt][FLIT_W-1]    : r_hold[w_slot_nxt][FLIT_W-1];
        w_sel_payload = w_accept ? w_in[w_slot_nxt][PAYLOAD_W-1:0] : r_hold[w_slot_nxt][PAYLOAD_W-1:0];
        w_inc_nxt     = '0;
        w_sig_nxt     = 4'b0000;
        if (w_state_nxt == ST_SEND) begin
            w_sig_nxt[w_slot_nxt] = 1'b1;
            if (w_sel_valid) begin
                w_inc_nxt = w_sel_payload;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_slot    <= 2'd0;
            r_gap_cnt <= 4'd0;
            r_inc     <= '0;
            r_sig     <= 4'b0000;
            r_clksig  <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_slot    <= w_slot_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_inc     <= w_inc_nxt;
            r_sig     <= w_sig_nxt;
            r_clksig  <= (w_state_nxt == ST_CLOSE);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_ovf     <= r_ovf | (frame_in && (r_state != ST_IDLE));
            if (w_accept) begin
                for (int i = 0; i < 4; i++) begin
                    r_hold[i] <= w_in[i];
                end
            end
        end
    end

    assign inc    = r_inc;
    assign nsig   = r_sig[0];
    assign ssig   = r_sig[1];
    assign esig   = r_sig[2];
    assign wsig   = r_sig[3];
    assign clksig = r_clksig;
    assign busy   = r_busy;
    assign ovf    = r_ovf;

    // Golden and direction bits never go on the link; they are only visible here.
    always_comb begin
        o_dbg_meta = '0;
        for (int i = 0; i < 4; i++) begin
            o_dbg_meta[i*3 +: 3] = r_hold[i][FLIT_W-2:PAYLOAD_W];
        end
    end

    assign o_dbg_state = r_state;
    assign o_dbg_slot  = r_slot;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_one_tx.sv
// Directed bench for pipeline_one_tx: one instance with GAP_CYCLES=0 and one with GAP_CYCLES=2.
`timescale 1ns/1ps

module tb_pipeline_one_tx;

    logic        clk;
    logic        rst_n;
    logic        fi_a;
    logic        fi_g;
    logic [10:0] fn, fs, fe, fw;

    logic [6:0]  inc_a, inc_g;
    logic        n_a, s_a, e_a, w_a, clk_a, busy_a, ovf_a;
    logic        n_g, s_g, e_g, w_g, clk_g, busy_g, ovf_g;
    logic [1:0]  st_a, sl_a, st_g, sl_g;
    logic [11:0] meta_a, meta_g;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle word: {ovf, busy, clksig, nsig, ssig, esig, wsig, inc[6:0]}
    logic [13:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    pipeline_one_tx #(.PAYLOAD_W(7), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .frame_in(fi_a),
        .noun(fn), .soun(fs), .eoun(fe), .woun(fw),
        .inc(inc_a), .nsig(n_a), .ssig(s_a), .esig(e_a), .wsig(w_a),
        .clksig(clk_a), .busy(busy_a), .ovf(ovf_a),
        .o_dbg_state(st_a), .o_dbg_slot(sl_a), .o_dbg_meta(meta_a)
    );

    pipeline_one_tx #(.PAYLOAD_W(7), .GAP_CYCLES(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .frame_in(fi_g),
        .noun(fn), .soun(fs), .eoun(fe), .woun(fw),
        .inc(inc_g), .nsig(n_g), .ssig(s_g), .esig(e_g), .wsig(w_g),
        .clksig(clk_g), .busy(busy_g), .ovf(ovf_g),
        .o_dbg_state(st_g), .o_dbg_slot(sl_g), .o_dbg_meta(meta_g)
    );

    function automatic logic [13:0] mk(input logic o, input logic b, input logic c,
                                       input logic [3:0] sg, input logic [6:0] d);
        return {o, b, c, sg, d};
    endfunction

    function automatic logic [13:0] obs_a();
        return {ovf_a, busy_a, clk_a, n_a, s_a, e_a, w_a, inc_a};
    endfunction

    function automatic logic [13:0] obs_g();
        return {ovf_g, busy_g, clk_g, n_g, s_g, e_g, w_g, inc_g};
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- drivers ----------------
    task automatic set_flits(input logic [10:0] a, input logic [10:0] b,
                             input logic [10:0] c, input logic [10:0] d);
        fn = a; fs = b; fe = c; fw = d;
    endtask

    // Full G=0 frame of the reference flits (five cycles, no trailing idle).
    task automatic push_full(input logic o);
        exp_q.push_back(mk(o, 1, 0, 4'b1000, 7'h05));
        exp_q.push_back(mk(o, 1, 0, 4'b0100, 7'h61));
        exp_q.push_back(mk(o, 1, 0, 4'b0010, 7'h24));
        exp_q.push_back(mk(o, 1, 0, 4'b0001, 7'h64));
        exp_q.push_back(mk(o, 1, 1, 4'b0000, 7'h00));
    endtask

    // Pulses frame_in for one edge, then compares one sampled word per cycle against exp_q.
    // reinject>0 raises frame_in again (with different flits) after sampling that cycle.
    task automatic run_frame(input string tag, input bit use_g, input int reinject);
        int n;
        logic [13:0] obs;
        n = exp_q.size();
        @(negedge clk);
        if (use_g) fi_g = 1'b1; else fi_a = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin fi_a = 1'b0; fi_g = 1'b0; end
            if (c == reinject + 1) fi_a = 1'b0;
            obs = use_g ? obs_g() : obs_a();
            chk($sformatf("%s_c%0d", tag, c), {50'd0, obs}, {50'd0, exp_q.pop_front()});
            if (c == reinject) begin
                fi_a = 1'b1;
                set_flits(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; fi_a = 1'b0; fi_g = 1'b0;
        set_flits(11'h000, 11'h000, 11'h000, 11'h000);
        repeat (3) @(negedge clk);
        chk("rst_a", {50'd0, obs_a()}, 64'd0);
        chk("rst_g", {50'd0, obs_g()}, 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle", {4'd0, obs_a(), obs_g(), st_a, sl_a, st_g, sl_g, meta_a, meta_g}, 64'd0);
        end

        // full frame, no gap
        set_flits(11'h405, 11'h461, 11'h424, 11'h464);
        push_full(0);
        exp_q.push_back(mk(0, 0, 0, 4'b0000, 7'h00));
        run_frame("full", 0, 0);

        // east slot invalid
        fe = 11'h024;
`ifdef TX_SKIP_INVALID_EN
        exp_q.push_back(mk(0, 1, 0, 4'b1000, 7'h05));
        exp_q.push_back(mk(0, 1, 0, 4'b0100, 7'h61));
        exp_q.push_back(mk(0, 1, 0, 4'b0001, 7'h64));
        exp_q.push_back(mk(0, 1, 1, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 0, 0, 4'b0000, 7'h00));
`else
        exp_q.push_back(mk(0, 1, 0, 4'b1000, 7'h05));
        exp_q.push_back(mk(0, 1, 0, 4'b0100, 7'h61));
        exp_q.push_back(mk(0, 1, 0, 4'b0010, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0001, 7'h64));
        exp_q.push_back(mk(0, 1, 1, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 0, 0, 4'b0000, 7'h00));
`endif
        run_frame("inval", 0, 0);

        // gap of 2 on the second instance: strobes 3 apart, clksig at cycle 13
        fe = 11'h424;
        exp_q.push_back(mk(0, 1, 0, 4'b1000, 7'h05));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0100, 7'h61));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0010, 7'h24));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0001, 7'h64));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 0, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 1, 1, 4'b0000, 7'h00));
        exp_q.push_back(mk(0, 0, 0, 4'b0000, 7'h00));
        run_frame("gap", 1, 0);

        // overflow: second request two cycles in, with different flits on the inputs
        exp_q.push_back(mk(0, 1, 0, 4'b1000, 7'h05));
        exp_q.push_back(mk(0, 1, 0, 4'b0100, 7'h61));
        exp_q.push_back(mk(1, 1, 0, 4'b0010, 7'h24));
        exp_q.push_back(mk(1, 1, 0, 4'b0001, 7'h64));
        exp_q.push_back(mk(1, 1, 1, 4'b0000, 7'h00));
        for (int c = 0; c < 4; c++) exp_q.push_back(mk(1, 0, 0, 4'b0000, 7'h00));
        run_frame("ovf", 0, 2);
        chk("ovf_meta", {52'd0, meta_a}, 64'd0);

        // reset after the ssig cycle
        set_flits(11'h405, 11'h461, 11'h424, 11'h464);
        exp_q.push_back(mk(1, 1, 0, 4'b1000, 7'h05));
        exp_q.push_back(mk(1, 1, 0, 4'b0100, 7'h61));
        run_frame("pre_rst", 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {50'd0, obs_a()}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_hold", {50'd0, obs_a()}, 64'd0);
        end
        rst_n = 1'b1;
        push_full(0);
        exp_q.push_back(mk(0, 0, 0, 4'b0000, 7'h00));
        run_frame("refill", 0, 0);

        // request in the CLOSE cycle is rejected and flagged
        push_full(0);
        for (int c = 0; c < 3; c++) exp_q.push_back(mk(1, 0, 0, 4'b0000, 7'h00));
        run_frame("close_ovf", 0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_one_tx.md
# pipeline_one_tx

Link-side transmitter for the MinBD router pipeline: the opposite end of the serial port-strobe interface that `pipeline_one` consumes. It captures the four 11-bit routed output flits (`noun`, `soun`, `eoun`, `woun`) as one frame. It then replays each valid flit onto a shared 7-bit `inc` bus with a one-cycle direction strobe (`nsig`/`ssig`/`esig`/`wsig`) and closes the frame with a one-cycle `clksig` pulse. This drives the next router's input stage.

## Interface
- `PAYLOAD_W`, 7: payload width; flit width is `PAYLOAD_W+4`.
- `GAP_CYCLES`, 0: idle cycles inserted after each emitted strobe. Range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `frame_in` in 1: capture request; samples the four flit inputs when not busy.
- `noun`, `soun`, `eoun`, `woun` in 11 each: flit fields are `[10]` valid, `[9]` golden, `[8:7]` productive-direction code, `[6:0]` payload.
- `inc` out 7: payload bus.
- `nsig`, `ssig`, `esig`, `wsig` out 1 each: direction strobes; at most one is high per cycle.
- `clksig` out 1: end-of-frame pulse.
- `busy` out 1: a frame is held or being sent.
- `ovf` out 1: sticky flag; `frame_in` arrived while busy.

## Operation
- FSM states:
  - IDLE: waits for a frame.
  - SEND: emits the slot selected by `slot[1:0]`. Order is 0=N, 1=S, 2=E, 3=W.
  - GAP: counts `GAP_CYCLES`.
  - CLOSE: pulses `clksig`.
- IDLE: on `frame_in`=1, latch all four flits into the hold registers, set `slot`=0, go to SEND, and set `busy`=1.
- SEND, slot valid (bit 10 = 1):
  - Drive `inc` = payload `[6:0]` and the matching strobe for exactly one cycle.
  - Then go to GAP if `GAP_CYCLES`>0, else advance the slot.
- SEND, slot invalid: behaviour is set by the configuration macro; see Configuration.
- Slot advance: if `slot`=3, go to CLOSE; else `slot`+1 and go to SEND.
- GAP: all strobes low and `inc`=0. After `GAP_CYCLES` cycles, advance the slot.
- CLOSE: `clksig`=1 for one cycle, `inc`=0. Next state is IDLE and `busy`=0.
- All four slots invalid: the frame still produces a CLOSE pulse, so the receiver sees an empty frame.
- `frame_in` while `busy`=1:
  - The request is ignored and `ovf` is set.
  - `ovf` clears only on reset.
  - The hold registers are not disturbed.
- `frame_in` in the CLOSE cycle counts as busy and sets `ovf`.
- Golden and direction bits are not transmitted; they are held for debug only.

## Timing
- All outputs are registered.
- Reset values:
  - `inc`=0, all strobes 0, `clksig`=0, `busy`=0, `ovf`=0.
  - FSM in IDLE, hold registers 0.
- Latency:
  - `frame_in` high at edge k gives the first strobe in cycle k+1.
  - With all slots emitted and `GAP_CYCLES`=G, the frame lasts 4·(1+G) cycles. `clksig` appears in cycle k+1+4·(1+G).
- `busy` rises at edge k and falls at the edge that ends CLOSE.
- Back-to-back frames: the earliest accepted next `frame_in` is the cycle after CLOSE.
- Reset mid-frame: all outputs go to reset values immediately (asynchronously). The remainder of the frame is dropped and no `clksig` is emitted.

## Configuration
- `TX_SKIP_INVALID_EN` defined:
  - SEND on an invalid slot emits nothing, takes zero bus cycles and no GAP, and advances within the same cycle.
  - Consecutive invalid slots are skipped combinationally via a priority search to the next valid slot.
  - The all-invalid frame goes straight to CLOSE in cycle k+1.
- `TX_SKIP_INVALID_EN` undefined:
  - An invalid slot still occupies its SEND cycle with its strobe high and `inc`=0, followed by GAP.
  - Frame length is always 4·(1+G)+1 cycles.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, release, `frame_in`=0 for 10 cycles. Required: all outputs stay 0.
- Full frame, G=0:
  - Stimulus: `noun`=0x405, `soun`=0x461, `eoun`=0x424, `woun`=0x464, `frame_in` pulse.
  - Required: `inc`=05/61/24/64 with `nsig`/`ssig`/`esig`/`wsig` in consecutive cycles, then `clksig`, then `busy`=0.
- Invalid slot: as above but `eoun`=0x024.
  - With `TX_SKIP_INVALID_EN`: strobes N, S, W, then `clksig` in cycle k+4.
  - Without it: `esig` is high with `inc`=0 in cycle k+3.
- Gap: `GAP_CYCLES`=2 with a full frame. Required: strobes 3 cycles apart, `clksig` in cycle k+13.
- Overflow: second `frame_in` pulse two cycles into a frame. Required: `ovf`=1 and sticky, the first frame's payloads are unchanged, and no second frame is sent.
- Mid-frame reset: assert `rst_n`=0 after the `ssig` cycle. Required: outputs are 0 immediately, no `clksig`, and a new frame after release transmits correctly from N.
